// File: rtl/ibex_cx_dispatcher.sv
// ibex_cx_dispatcher: routes custom-extension instructions to one of NUM_CX attached units.
// Revision 1.0 - initial release.
`default_nettype none

module ibex_cx_dispatcher #(
  parameter int NUM_CX  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cx_valid_i,
  input  logic [6:0]           cx_opcode_i,
  input  logic [9:0]           cx_funct_i,
  input  logic [31:0]          cx_op_a_i,
  input  logic [31:0]          cx_op_b_i,
  output logic                 cx_busy_o,
  output logic                 cx_done_o,
  output logic                 cx_err_o,
  output logic [31:0]          cx_result_o,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic [NUM_CX-1:0]    unit_req_o,
  output logic [9:0]           unit_funct_o,
  output logic [31:0]          unit_op_a_o,
  output logic [31:0]          unit_op_b_o,
  input  logic [NUM_CX-1:0]    unit_gnt_i,
  input  logic [NUM_CX-1:0]    unit_rvalid_i,
  input  logic [NUM_CX-1:0]    unit_err_i,
  input  logic [NUM_CX*32-1:0] unit_rdata_i
);

  localparam int IDX_W = (NUM_CX > 1) ? $clog2(NUM_CX) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [11:0] ADDR_SEL  = 12'h400;
  localparam logic [11:0] ADDR_STAT = 12'h401;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state;
  logic                sel_en;
  logic [3:0]          sel_idx;
  logic                stat_tmo;
  logic                stat_uerr;
  logic                stat_ill;
  logic [7:0]          stat_cnt;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [NUM_CX-1:0]   req;
  logic [9:0]          funct;
  logic [31:0]         op_a;
  logic [31:0]         op_b;
  logic                done;
  logic                err;
  logic [31:0]         result;

  logic                legal_op;
  logic                sel_bad;
  logic                sel_gnt;
  logic                sel_rvalid;
  logic                sel_err;
  logic [31:0]         sel_rdata;
  logic                tmo_hit;
  logic                unused_wdata;

  assign legal_op   = (cx_opcode_i == 7'h0B) || (cx_opcode_i == 7'h2B) || (cx_opcode_i == 7'h5B);
  assign sel_bad    = !sel_en || ({28'd0, sel_idx} >= 32'(NUM_CX));
  assign sel_gnt    = unit_gnt_i[idx];
  assign sel_rvalid = unit_rvalid_i[idx];
  assign sel_err    = unit_err_i[idx];
  assign sel_rdata  = unit_rdata_i[int'(idx)*32 +: 32];
  assign tmo_hit    = (tmo_cnt >= TMO_LAST);
  assign unused_wdata = ^csr_wdata_i[30:4];

  assign cx_busy_o    = (state != IDLE);
  assign cx_done_o    = done;
  assign cx_err_o     = err;
  assign cx_result_o  = result;
  assign unit_req_o   = req;
  assign unit_funct_o = funct;
  assign unit_op_a_o  = op_a;
  assign unit_op_b_o  = op_b;

  always_comb begin
    csr_rdata_o = 32'd0;
    case (csr_addr_i)
      ADDR_SEL:  csr_rdata_o = {sel_en, 27'd0, sel_idx};
      ADDR_STAT: csr_rdata_o = {16'd0, stat_cnt, 5'd0, stat_ill, stat_uerr, stat_tmo};
      default:   csr_rdata_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sel_en    <= 1'b0;
      sel_idx   <= 4'd0;
      stat_tmo  <= 1'b0;
      stat_uerr <= 1'b0;
      stat_ill  <= 1'b0;
      stat_cnt  <= 8'd0;
      idx       <= '0;
      tmo_cnt   <= '0;
      req       <= '0;
      funct     <= 10'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= 32'd0;
    end else begin
      done <= 1'b0;

      if (csr_we_i && csr_addr_i == ADDR_SEL) begin
        sel_en  <= csr_wdata_i[31];
        sel_idx <= csr_wdata_i[3:0];
      end
      // A same-cycle completion event still lands on top of the clear.
      if (csr_we_i && csr_addr_i == ADDR_STAT) begin
        stat_tmo  <= 1'b0;
        stat_uerr <= 1'b0;
        stat_ill  <= 1'b0;
        stat_cnt  <= 8'd0;
      end

      case (state)
        IDLE: begin
          if (cx_valid_i && legal_op) begin
            tmo_cnt <= '0;
            if (sel_bad) begin
              state    <= RESP;
              done     <= 1'b1;
              err      <= 1'b1;
              result   <= 32'd0;
              stat_ill <= 1'b1;
            end else begin
              state <= REQ;
              idx   <= sel_idx[IDX_W-1:0];
              req   <= NUM_CX'(1) << sel_idx[IDX_W-1:0];
              funct <= cx_funct_i;
              op_a  <= cx_op_a_i;
              op_b  <= cx_op_b_i;
            end
          end
        end

        REQ, WAIT: begin
          if (sel_rvalid && (state == WAIT || sel_gnt)) begin
            state  <= RESP;
            req    <= '0;
            done   <= 1'b1;
            err    <= sel_err;
            result <= sel_err ? 32'd0 : sel_rdata;
            if (sel_err) stat_uerr <= 1'b1;
            else         stat_cnt  <= stat_cnt + 8'd1;
          end else if (tmo_hit) begin
            state    <= RESP;
            req      <= '0;
            done     <= 1'b1;
            err      <= 1'b1;
            result   <= 32'd0;
            stat_tmo <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (state == REQ && sel_gnt) begin
              state <= WAIT;
              req   <= '0;
            end
          end
        end

        RESP: begin
          state  <= IDLE;
          err    <= 1'b0;
          result <= 32'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ibex_cx_dispatcher.sv
// tb_ibex_cx_dispatcher: directed self-checking bench for ibex_cx_dispatcher (NUM_CX=4, TIMEOUT=255).
`default_nettype none

module tb_ibex_cx_dispatcher;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cx_valid_i;
  logic [6:0]   cx_opcode_i;
  logic [9:0]   cx_funct_i;
  logic [31:0]  cx_op_a_i;
  logic [31:0]  cx_op_b_i;
  logic         cx_busy_o;
  logic         cx_done_o;
  logic         cx_err_o;
  logic [31:0]  cx_result_o;
  logic         csr_we_i;
  logic [11:0]  csr_addr_i;
  logic [31:0]  csr_wdata_i;
  logic [31:0]  csr_rdata_o;
  logic [3:0]   unit_req_o;
  logic [9:0]   unit_funct_o;
  logic [31:0]  unit_op_a_o;
  logic [31:0]  unit_op_b_o;
  logic [3:0]   unit_gnt_i;
  logic [3:0]   unit_rvalid_i;
  logic [3:0]   unit_err_i;
  logic [127:0] unit_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_cx_dispatcher #(.NUM_CX(4), .TIMEOUT(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cx_valid_i(cx_valid_i), .cx_opcode_i(cx_opcode_i), .cx_funct_i(cx_funct_i),
    .cx_op_a_i(cx_op_a_i), .cx_op_b_i(cx_op_b_i),
    .cx_busy_o(cx_busy_o), .cx_done_o(cx_done_o), .cx_err_o(cx_err_o), .cx_result_o(cx_result_o),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .unit_req_o(unit_req_o), .unit_funct_o(unit_funct_o),
    .unit_op_a_o(unit_op_a_o), .unit_op_b_o(unit_op_b_o),
    .unit_gnt_i(unit_gnt_i), .unit_rvalid_i(unit_rvalid_i), .unit_err_i(unit_err_i),
    .unit_rdata_i(unit_rdata_i)
  );

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
    tick();
    csr_we_i = 1'b0; csr_wdata_i = 32'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    checks++; if (cx_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", cx_busy_o); end
    checks++; if (cx_done_o !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", cx_done_o); end
    checks++; if (unit_req_o !== 4'b0) begin errors++; $display("FAIL reset_req actual=%b required=0000", unit_req_o); end
    csr_addr_i = 12'h400; #1;
    checks++; if (csr_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_sel actual=%h required=0", csr_rdata_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_stat actual=%h required=0", csr_rdata_o); end
  endtask

  task automatic test_basic();
    csr_write(12'h400, 32'h8000_0001);
    csr_addr_i = 12'h400; #1;
    checks++; if (csr_rdata_o !== 32'h8000_0001) begin errors++; $display("FAIL sel_readback actual=%h required=80000001", csr_rdata_o); end
    // cycle 0
    cx_valid_i = 1'b1; cx_opcode_i = 7'h0B; cx_funct_i = 10'h155; cx_op_a_i = 32'd5; cx_op_b_i = 32'd7;
    tick(); // cycle 1
    cx_valid_i = 1'b0;
    checks++; if (unit_req_o !== 4'b0010) begin errors++; $display("FAIL basic_req actual=%b required=0010", unit_req_o); end
    checks++; if ({unit_funct_o, unit_op_a_o, unit_op_b_o} !== {10'h155, 32'd5, 32'd7})
      begin errors++; $display("FAIL basic_fields actual=%h/%h/%h required=155/5/7", unit_funct_o, unit_op_a_o, unit_op_b_o); end
    unit_gnt_i = 4'b0010;
    tick(); // cycle 2
    unit_gnt_i = 4'b0; unit_rvalid_i = 4'b0010; unit_rdata_i[63:32] = 32'd12;
    checks++; if (cx_done_o !== 1'b0 || cx_busy_o !== 1'b1) begin errors++; $display("FAIL basic_wait actual=done%b busy%b required=done0 busy1", cx_done_o, cx_busy_o); end
    tick(); // cycle 3
    unit_rvalid_i = 4'b0;
    checks++; if ({cx_done_o, cx_err_o, cx_result_o} !== {1'b1, 1'b0, 32'd12})
      begin errors++; $display("FAIL basic_done actual=done%b err%b res%0d required=done1 err0 res12", cx_done_o, cx_err_o, cx_result_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'h0000_0100) begin errors++; $display("FAIL basic_stat actual=%h required=00000100", csr_rdata_o); end
    tick(); // cycle 4
    checks++; if (cx_done_o !== 1'b0 || cx_busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle actual=done%b busy%b required=0 0", cx_done_o, cx_busy_o); end
  endtask

  task automatic test_illegal_select();
    csr_write(12'h401, 32'd0);
    csr_write(12'h400, 32'h0000_0001);
    cx_valid_i = 1'b1; cx_opcode_i = 7'h2B;
    tick();
    cx_valid_i = 1'b0;
    checks++; if ({cx_done_o, cx_err_o, cx_result_o, unit_req_o} !== {1'b1, 1'b1, 32'd0, 4'b0})
      begin errors++; $display("FAIL disabled_done actual=done%b err%b res%h req%b required=1 1 0 0000", cx_done_o, cx_err_o, cx_result_o, unit_req_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'h4) begin errors++; $display("FAIL disabled_stat actual=%h required=4", csr_rdata_o); end
    tick();
    // out-of-range index with enable set; unmapped bits must read back as zero
    csr_write(12'h401, 32'd0);
    csr_write(12'h400, 32'h8000_00F5);
    csr_addr_i = 12'h400; #1;
    checks++; if (csr_rdata_o !== 32'h8000_0005) begin errors++; $display("FAIL sel_mask actual=%h required=80000005", csr_rdata_o); end
    cx_valid_i = 1'b1; cx_opcode_i = 7'h5B;
    tick();
    cx_valid_i = 1'b0;
    checks++; if ({cx_done_o, cx_err_o, unit_req_o} !== {1'b1, 1'b1, 4'b0})
      begin errors++; $display("FAIL badidx_done actual=done%b err%b req%b required=1 1 0000", cx_done_o, cx_err_o, unit_req_o); end
    tick();
  endtask

  task automatic test_ignore_and_clear();
    csr_write(12'h400, 32'h8000_0000);
    cx_valid_i = 1'b1; cx_opcode_i = 7'h33;
    tick();
    cx_valid_i = 1'b0;
    checks++; if (cx_busy_o !== 1'b0 || unit_req_o !== 4'b0) begin errors++; $display("FAIL ignore_op actual=busy%b req%b required=0 0000", cx_busy_o, unit_req_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'h4) begin errors++; $display("FAIL stat_before_clear actual=%h required=4", csr_rdata_o); end
    csr_write(12'h401, 32'hFFFF_FFFF);
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'd0) begin errors++; $display("FAIL stat_clear actual=%h required=0", csr_rdata_o); end
    csr_write(12'h402, 32'hFFFF_FFFF);
    csr_addr_i = 12'h402; #1;
    checks++; if (csr_rdata_o !== 32'd0) begin errors++; $display("FAIL unmapped_read actual=%h required=0", csr_rdata_o); end
    csr_addr_i = 12'h400; #1;
    checks++; if (csr_rdata_o !== 32'h8000_0000) begin errors++; $display("FAIL unmapped_write actual=%h required=80000000", csr_rdata_o); end
  endtask

  task automatic test_wrong_unit();
    csr_write(12'h401, 32'd0);
    csr_write(12'h400, 32'h8000_0000);
    cx_valid_i = 1'b1; cx_opcode_i = 7'h5B;
    tick(); // cycle 1: REQ unit0; foreign grant and a select rewrite
    cx_valid_i = 1'b0;
    unit_gnt_i = 4'b0100;
    csr_we_i = 1'b1; csr_addr_i = 12'h400; csr_wdata_i = 32'h8000_0002;
    tick(); // cycle 2
    csr_we_i = 1'b0; unit_gnt_i = 4'b0;
    checks++; if (unit_req_o !== 4'b0001) begin errors++; $display("FAIL foreign_gnt actual=%b required=0001", unit_req_o); end
    unit_gnt_i = 4'b0001;
    tick(); // cycle 3: WAIT
    unit_gnt_i = 4'b0; unit_rvalid_i = 4'b0100; unit_rdata_i[95:64] = 32'hDEAD;
    tick(); // cycle 4
    unit_rvalid_i = 4'b0;
    checks++; if (cx_done_o !== 1'b0 || cx_busy_o !== 1'b1) begin errors++; $display("FAIL foreign_rvalid actual=done%b busy%b required=0 1", cx_done_o, cx_busy_o); end
    unit_rvalid_i = 4'b0001; unit_err_i = 4'b0001; unit_rdata_i[31:0] = 32'h1234;
    tick(); // cycle 5
    unit_rvalid_i = 4'b0; unit_err_i = 4'b0;
    checks++; if ({cx_done_o, cx_err_o, cx_result_o} !== {1'b1, 1'b1, 32'd0})
      begin errors++; $display("FAIL unit_err actual=done%b err%b res%h required=1 1 0", cx_done_o, cx_err_o, cx_result_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'h2) begin errors++; $display("FAIL unit_err_stat actual=%h required=2", csr_rdata_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    csr_write(12'h400, 32'h8000_0003);
    cx_valid_i = 1'b1; cx_opcode_i = 7'h0B;
    tick(); // cycle 1: REQ; valid stays high and must be ignored
    unit_gnt_i = 4'b1000; unit_rvalid_i = 4'b1000; unit_rdata_i[127:96] = 32'hA5A5_0001;
    tick(); // cycle 2
    unit_gnt_i = 4'b0; unit_rvalid_i = 4'b0; cx_valid_i = 1'b0;
    checks++; if ({cx_done_o, cx_err_o, cx_result_o} !== {1'b1, 1'b0, 32'hA5A5_0001})
      begin errors++; $display("FAIL same_cycle actual=done%b err%b res%h required=1 0 a5a50001", cx_done_o, cx_err_o, cx_result_o); end
    tick();
    checks++; if (cx_busy_o !== 1'b0) begin errors++; $display("FAIL valid_in_op actual=busy%b required=0", cx_busy_o); end
  endtask

  task automatic test_timeout();
    int done_cyc;
    done_cyc = -1;
    csr_write(12'h401, 32'd0);
    csr_write(12'h400, 32'h8000_0002);
    cx_valid_i = 1'b1; cx_opcode_i = 7'h2B;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      tick();
      cx_valid_i = 1'b0;
      if (cx_done_o === 1'b1) done_cyc = c;
      if (c == 255) begin
        checks++; if (unit_req_o !== 4'b0100) begin errors++; $display("FAIL tmo_req_held actual=%b required=0100", unit_req_o); end
      end
    end
    checks++; if (done_cyc != 256) begin errors++; $display("FAIL tmo_cycle actual=%0d required=256", done_cyc); end
    checks++; if (cx_err_o !== 1'b1 || unit_req_o !== 4'b0) begin errors++; $display("FAIL tmo_err actual=err%b req%b required=1 0000", cx_err_o, unit_req_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'h1) begin errors++; $display("FAIL tmo_stat actual=%h required=1", csr_rdata_o); end
    tick();
    checks++; if (unit_req_o !== 4'b0 || cx_busy_o !== 1'b0) begin errors++; $display("FAIL tmo_after actual=req%b busy%b required=0000 0", unit_req_o, cx_busy_o); end
  endtask

  task automatic test_reset_mid();
    csr_write(12'h400, 32'h8000_0001);
    cx_valid_i = 1'b1; cx_opcode_i = 7'h0B; cx_op_a_i = 32'h77;
    tick();
    cx_valid_i = 1'b0; unit_gnt_i = 4'b0010;
    tick(); // WAIT
    unit_gnt_i = 4'b0;
    checks++; if (cx_busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy actual=%b required=1", cx_busy_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if ({cx_busy_o, cx_done_o, unit_req_o, unit_op_a_o} !== {1'b0, 1'b0, 4'b0, 32'd0})
      begin errors++; $display("FAIL mid_reset actual=busy%b done%b req%b a%h required=0 0 0000 0", cx_busy_o, cx_done_o, unit_req_o, unit_op_a_o); end
    csr_addr_i = 12'h400; #1;
    checks++; if (csr_rdata_o !== 32'd0) begin errors++; $display("FAIL mid_sel actual=%h required=0", csr_rdata_o); end
    csr_addr_i = 12'h401; #1;
    checks++; if (csr_rdata_o !== 32'd0) begin errors++; $display("FAIL mid_stat actual=%h required=0", csr_rdata_o); end
  endtask

  initial begin
    rst_i = 1'b1; cx_valid_i = 1'b0; cx_opcode_i = 7'd0; cx_funct_i = 10'd0;
    cx_op_a_i = 32'd0; cx_op_b_i = 32'd0; csr_we_i = 1'b0; csr_addr_i = 12'd0; csr_wdata_i = 32'd0;
    unit_gnt_i = 4'b0; unit_rvalid_i = 4'b0; unit_err_i = 4'b0; unit_rdata_i = '0;
    tick();
    test_reset();
    test_basic();
    test_illegal_select();
    test_ignore_and_clear();
    test_wrong_unit();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
